// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one
// single-port memory, with data priority bounded by a starvation counter.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

   state_t            state_reg;
   logic [SW-1:0]     streak_reg;
   logic              mem_req_reg;
   logic              mem_we_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_wdata_reg;

   logic grant_d;
   logic streak_full;

   // Data wins a collision until the fetch has been passed over LIMIT times.
   assign streak_full = (streak_reg == LIMIT);
   assign grant_d     = d_req && (!i_req || !streak_full);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         streak_reg    <= '0;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant_d) begin
                  state_reg     <= SERVE_D;
                  mem_req_reg   <= 1'b1;
                  mem_we_reg    <= d_we;
                  mem_addr_reg  <= d_addr;
                  mem_wdata_reg <= d_wdata;
                  if (!i_req)
                     streak_reg <= '0;
                  else if (!streak_full)
                     streak_reg <= streak_reg + SW'(1);
               end else if (i_req) begin
                  state_reg    <= SERVE_I;
                  mem_req_reg  <= 1'b1;
                  mem_we_reg   <= 1'b0;
                  mem_addr_reg <= i_addr;
                  streak_reg   <= '0;
               end
            end
            SERVE_I, SERVE_D: begin
               if (mem_ack) begin
                  state_reg   <= IDLE;
                  mem_req_reg <= 1'b0;
                  mem_we_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg   <= IDLE;
               mem_req_reg <= 1'b0;
               mem_we_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Acks are combinational from mem_ack; reset masks a completion in flight.
   assign i_ack   = !reset && (state_reg == SERVE_I) && mem_ack;
   assign d_ack   = !reset && (state_reg == SERVE_D) && mem_ack;
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

   assign mem_req   = mem_req_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the byte-address width of all ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width of all ports.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive data grants while a fetch waits.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-005 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-006 The block SHALL have port i_req, input, 1, the instruction-fetch read request.
REQ-007 The block SHALL have port i_addr, input, ADDR_W, the fetch byte address (PC).
REQ-008 The block SHALL have port i_ack, output, 1, which pulses for one cycle when the fetch completes.
REQ-009 The block SHALL have port i_rdata, output, DATA_W, the fetched instruction, valid only while i_ack=1.
REQ-010 The block SHALL have port d_req, input, 1, the load/store request from the MEM stage.
REQ-011 The block SHALL have port d_we, input, 1, where 1 means store (SW) and 0 means load (LW).
REQ-012 The block SHALL have port d_addr, input, ADDR_W, the effective byte address.
REQ-013 The block SHALL have port d_wdata, input, DATA_W, the store data.
REQ-014 The block SHALL have port d_ack, output, 1, which pulses for one cycle when the data access completes.
REQ-015 The block SHALL have port d_rdata, output, DATA_W, the load data, valid only while d_ack=1.
REQ-016 The block SHALL have port mem_req, output, 1, the unified single-port memory request, registered.
REQ-017 The block SHALL have port mem_we, output, 1, the memory write enable, registered.
REQ-018 The block SHALL have port mem_addr, output, ADDR_W, the memory byte address, registered.
REQ-019 The block SHALL have port mem_wdata, output, DATA_W, the memory write data, registered.
REQ-020 The block SHALL have port mem_ack, input, 1, the memory completion; it may assert in the first cycle mem_req=1.
REQ-021 The block SHALL have port mem_rdata, input, DATA_W, the memory read data, valid with mem_ack.

Function
REQ-022 The FSM SHALL have the states IDLE, SERVE_I and SERVE_D; in at most one state at any time.
REQ-023 In IDLE with only i_req=1: next state SERVE_I; latch mem_addr=i_addr, mem_we=0, and set mem_req=1.
REQ-024 In IDLE with only d_req=1: next state SERVE_D; latch mem_addr=d_addr, mem_we=d_we, mem_wdata=d_wdata, and set mem_req=1.
REQ-025 In IDLE with both requests asserted, data SHALL win unless streak==STARVE_LIMIT, in which case fetch wins.
REQ-026 streak: a D grant while i_req=1 SHALL increment streak (saturating at STARVE_LIMIT); a D grant while i_req=0 or any I grant SHALL clear it.
REQ-027 In SERVE_x, mem_req and the latched fields SHALL hold until mem_ack=1; there is no timeout.
REQ-028 In SERVE_I with mem_ack=1: i_ack=1 and i_rdata=mem_rdata in the same cycle (combinational); next state IDLE; mem_req=0 next cycle.
REQ-029 In SERVE_D with mem_ack=1: d_ack=1, plus d_rdata=mem_rdata for a load; next state IDLE; mem_req=0 next cycle.
REQ-030 Minimum transaction SHALL take 2 cycles (grant cycle, then ack cycle), with at most one outstanding memory request.
REQ-031 A requester deasserting req before its ack SHALL NOT abort the transaction; the access completes and ack still pulses.
REQ-032 A requester holding req high after ack SHALL be treated as a new request, arbitrated in the following IDLE cycle.
REQ-033 mem_ack in IDLE SHALL be ignored, with i_ack=d_ack=0.
REQ-034 i_ack and d_ack SHALL never be asserted in the same cycle.
REQ-035 mem_we SHALL be 0 whenever mem_req=0 and during every SERVE_I.
REQ-036 Addresses SHALL pass unmodified; alignment is the requester's responsibility.

Reset
REQ-037 While reset=1 at posedge clk: state=IDLE, streak=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-038 i_ack=d_ack=0 while reset=1, including reset asserted mid-SERVE with mem_ack=1 in the same cycle.
REQ-039 A transaction interrupted by reset SHALL be dropped; no ack SHALL follow after reset deasserts.

Verification
REQ-040 Single fetch: i_req=1, i_addr=0x8, memory acks 1 cycle later with rdata=0x00000013 -> mem_addr=0x8 and mem_we=0; i_ack pulses once with i_rdata=0x00000013 (NOP).
REQ-041 Store: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF held until mem_ack; d_ack pulses once.
REQ-042 Collision: i_req and d_req both held continuously with STARVE_LIMIT=4 and mem_ack after 1 cycle -> grant order D,D,D,D,I,D,D,D,D,I...
REQ-043 Wait states: mem_ack delayed 5 cycles -> mem_req and mem_addr stable for all 5 cycles; exactly one ack.
REQ-044 Reset mid-access: reset=1 in SERVE_D coincident with mem_ack=1 -> d_ack=0 and mem_req=0 next cycle; stray mem_ack in IDLE afterwards produces no ack.
